// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions for the data-memory write buffer.
// Holds the default buffer depth and the bus FSM encoding.
package mips_mem_pkg;

  localparam int WBUF_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2,
    RD_DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write FIFO with an age-ordered view of every entry.
// Entry 0 of the view is the head (oldest), higher indices are younger.
module wbuf_fifo
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEF,
  parameter int EW    = 30
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [EW-1:0]              i_addr,
  input  logic [31:0]                i_data,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [DEPTH-1:0]           o_ent_vld,
  output logic [DEPTH-1:0][EW-1:0]   o_ent_addr,
  output logic [DEPTH-1:0][31:0]     o_ent_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic [EW-1:0] r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];

  logic [PW:0]   w_count;
  logic [PW-1:0] w_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) &&
                   (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

  // A push into a full buffer is legal when the head leaves on the same edge
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_addr[r_wptr[PW-1:0]] <= i_addr;
        r_data[r_wptr[PW-1:0]] <= i_data;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_comb begin
    w_idx      = '0;
    o_ent_vld  = '0;
    o_ent_addr = '0;
    o_ent_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx         = r_rptr[PW-1:0] + PW'(k);
      o_ent_vld[k]  = ((PW+1)'(k) < w_count);
      o_ent_addr[k] = r_addr[w_idx];
      o_ent_data[k] = r_data[w_idx];
    end
  end

endmodule

// File: rtl/dmem_wbuf_ctrl.sv
// MEM-stage data-memory controller: posted write buffer with
// store-to-load forwarding and a single outstanding bus transaction.
module dmem_wbuf_ctrl
  import mips_mem_pkg::*;
#(
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEF,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread_mem,
  input  logic          memwrite_mem,
  input  logic [AW-1:0] aluout_mem,
  input  logic [31:0]   writedata_mem,
  output logic [31:0]   readdata_mem,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata
);

  localparam int EW = AW - 2;

  mem_state_e r_state;
  mem_state_e w_state_nx;

  logic          r_bus_req;
  logic          r_bus_we;
  logic [AW-1:0] r_bus_addr;
  logic [31:0]   r_bus_wdata;
  logic [31:0]   r_rdata;

  logic          w_bus_req_nx;
  logic          w_bus_we_nx;
  logic [AW-1:0] w_bus_addr_nx;
  logic [31:0]   w_bus_wdata_nx;
  logic [31:0]   w_rdata_nx;

  logic          w_wr;
  logic          w_rd;
  logic          w_ack;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_hit;
  logic          w_miss;
  logic          w_rd_done;
  logic [31:0]   w_hit_data;
  logic [EW-1:0] w_word;
  logic          w_unused;

  logic [WBUF_DEPTH-1:0]         w_ent_vld;
  logic [WBUF_DEPTH-1:0][EW-1:0] w_ent_addr;
  logic [WBUF_DEPTH-1:0][31:0]   w_ent_data;

  assign w_word   = aluout_mem[AW-1:2];
  assign w_unused = ^aluout_mem[1:0];

  // A store wins when both requests are raised together
  assign w_wr      = memwrite_mem;
  assign w_rd      = memread_mem & ~memwrite_mem;
  assign w_ack     = bus_ack & r_bus_req;
  assign w_pop     = (r_state == WR_BUSY) & w_ack;
  assign w_rd_done = (r_state == RD_DONE);

  wbuf_fifo #(
    .DEPTH (WBUF_DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_wr),
    .i_addr     (w_word),
    .i_data     (writedata_mem),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_ent_vld  (w_ent_vld),
    .o_ent_addr (w_ent_addr),
    .o_ent_data (w_ent_data)
  );

  // Scan oldest to youngest so the youngest match is the one kept
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if (w_ent_vld[k] && (w_ent_addr[k] == w_word)) begin
        w_hit      = 1'b1;
        w_hit_data = w_ent_data[k];
      end
    end
  end

  assign w_miss = w_rd & ~w_hit;

  always_comb begin
    w_state_nx     = r_state;
    w_bus_req_nx   = r_bus_req;
    w_bus_we_nx    = r_bus_we;
    w_bus_addr_nx  = r_bus_addr;
    w_bus_wdata_nx = r_bus_wdata;
    w_rdata_nx     = r_rdata;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nx     = WR_BUSY;
          w_bus_req_nx   = 1'b1;
          w_bus_we_nx    = 1'b1;
          w_bus_addr_nx  = {w_ent_addr[0], 2'b00};
          w_bus_wdata_nx = w_ent_data[0];
        end else if (w_miss) begin
          w_state_nx    = RD_BUSY;
          w_bus_req_nx  = 1'b1;
          w_bus_we_nx   = 1'b0;
          w_bus_addr_nx = {w_word, 2'b00};
        end
      end
      WR_BUSY: begin
        if (w_ack) begin
          w_state_nx   = IDLE;
          w_bus_req_nx = 1'b0;
        end
      end
      RD_BUSY: begin
        if (w_ack) begin
          w_state_nx   = RD_DONE;
          w_bus_req_nx = 1'b0;
          w_rdata_nx   = bus_rdata;
        end
      end
      RD_DONE: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_bus_req   <= w_bus_req_nx;
      r_bus_we    <= w_bus_we_nx;
      r_bus_addr  <= w_bus_addr_nx;
      r_bus_wdata <= w_bus_wdata_nx;
      r_rdata     <= w_rdata_nx;
    end
  end

  always_comb begin
    readdata_mem = '0;
    unique case (1'b1)
      w_rd_done:                  readdata_mem = r_rdata;
      (!w_rd_done && w_rd && w_hit): readdata_mem = w_hit_data;
      default:                    readdata_mem = '0;
    endcase
  end

  // Full-buffer store waits for a drain; a miss waits until its data is shown
  assign stall = (w_wr & w_full & ~w_pop) | (w_miss & ~w_rd_done);

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_dmem_wbuf_ctrl.sv
// Directed table-driven bench for dmem_wbuf_ctrl plus hand-written
// sequences for drain ordering and mid-transaction reset.
module tb_dmem_wbuf_ctrl;

  logic        clk;
  logic        reset;
  logic        memread_mem;
  logic        memwrite_mem;
  logic [31:0] aluout_mem;
  logic [31:0] writedata_mem;
  logic [31:0] readdata_mem;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_chk;
  int n_err;

  dmem_wbuf_ctrl #(
    .WBUF_DEPTH (4),
    .AW         (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .memread_mem   (memread_mem),
    .memwrite_mem  (memwrite_mem),
    .aluout_mem    (aluout_mem),
    .writedata_mem (writedata_mem),
    .readdata_mem  (readdata_mem),
    .stall         (stall),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] brd;
    logic        e_stall;
    logic [31:0] e_rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_baddr;
    logic [31:0] e_bwd;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic ack, input logic [31:0] brd,
                     input logic e_stall, input logic [31:0] e_rdata,
                     input logic e_req, input logic e_we,
                     input logic [31:0] e_baddr,
                     input logic [31:0] e_bwd, input int e_cnt);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
    v.ack = ack; v.brd = brd;
    v.e_stall = e_stall; v.e_rdata = e_rdata;
    v.e_req = e_req; v.e_we = e_we;
    v.e_baddr = e_baddr; v.e_bwd = e_bwd; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic ack, input logic [31:0] brd);
    memread_mem   = rd;
    memwrite_mem  = wr;
    aluout_mem    = addr;
    writedata_mem = wd;
    bus_ack       = ack;
    bus_rdata     = brd;
  endtask

  function automatic logic [31:0] cnt();
    return 32'(dut.u_fifo.w_count);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic        tx_we [4];
    logic [31:0] tx_addr [4];
    logic [31:0] tx_wd [4];
    int          ntx;
    bit          done;

    n_chk = 0;
    n_err = 0;

    // S1: single posted store, bus write held until ack
    add(0,1,32'h100,32'h11111111,0,0, 0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,                  0,0,0,0,0,0,1);
    add(0,0,0,0,0,0,                  0,0,1,1,32'h100,32'h11111111,1);
    add(0,0,0,0,1,0,                  0,0,1,1,32'h100,32'h11111111,1);
    add(0,0,0,0,0,0,                  0,0,0,0,0,0,0);
    // S2: five stores, fifth waits for first drain
    add(0,1,32'h10,32'd1,0,0,         0,0,0,0,0,0,0);
    add(0,1,32'h14,32'd2,0,0,         0,0,0,0,0,0,1);
    add(0,1,32'h18,32'd3,0,0,         0,0,1,1,32'h10,32'd1,2);
    add(0,1,32'h1C,32'd4,0,0,         0,0,1,1,32'h10,32'd1,3);
    add(0,1,32'h20,32'd5,0,0,         1,0,1,1,32'h10,32'd1,4);
    add(0,1,32'h20,32'd5,0,0,         1,0,1,1,32'h10,32'd1,4);
    add(0,1,32'h20,32'd5,1,0,         0,0,1,1,32'h10,32'd1,4);
    add(0,0,0,0,0,0,                  0,0,0,0,0,0,4);
    add(0,0,0,0,1,0,                  0,0,1,1,32'h14,32'd2,4);
    add(0,0,0,0,0,0,                  0,0,0,0,0,0,3);
    add(0,0,0,0,1,0,                  0,0,1,1,32'h18,32'd3,3);
    add(0,0,0,0,0,0,                  0,0,0,0,0,0,2);
    add(0,0,0,0,1,0,                  0,0,1,1,32'h1C,32'd4,2);
    add(0,0,0,0,0,0,                  0,0,0,0,0,0,1);
    add(0,0,0,0,1,0,                  0,0,1,1,32'h20,32'd5,1);
    add(0,0,0,0,0,0,                  0,0,0,0,0,0,0);
    // S3: youngest of two same-address stores is forwarded
    add(0,1,32'h200,32'hA,0,0,        0,0,0,0,0,0,0);
    add(0,1,32'h200,32'hB,0,0,        0,0,0,0,0,0,1);
    add(1,0,32'h202,0,0,0,            0,32'hB,1,1,32'h200,32'hA,2);
    add(1,0,32'h204,0,0,0,            1,0,1,1,32'h200,32'hA,2);
    add(0,0,0,0,1,0,                  0,0,1,1,32'h200,32'hA,2);
    add(0,0,0,0,0,0,                  0,0,0,0,0,0,1);
    add(0,0,0,0,1,0,                  0,0,1,1,32'h200,32'hB,1);
    add(0,0,0,0,0,0,                  0,0,0,0,0,0,0);
    // S4: load miss, ack in third bus cycle
    add(1,0,32'h300,0,0,0,            1,0,0,0,0,0,0);
    add(1,0,32'h300,0,0,0,            1,0,1,0,32'h300,0,0);
    add(1,0,32'h300,0,0,0,            1,0,1,0,32'h300,0,0);
    add(1,0,32'h300,0,1,32'hDEADBEEF, 1,0,1,0,32'h300,0,0);
    add(1,0,32'h300,0,0,0,            0,32'hDEADBEEF,0,0,0,0,0);
    add(0,0,0,0,0,0,                  0,0,0,0,0,0,0);
    // Read+write together: write wins, then forwarded; stray ack ignored
    add(1,1,32'h600,32'h77,0,0,       0,0,0,0,0,0,0);
    add(1,0,32'h600,0,0,0,            0,32'h77,0,0,0,0,1);
    add(0,0,0,0,1,0,                  0,0,1,1,32'h600,32'h77,1);
    add(0,0,0,0,1,0,                  0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,                  0,0,0,0,0,0,0);

    drive(0,0,0,0,0,0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_req",   32'(bus_req), 0);
    chk("rst_we",    32'(bus_we), 0);
    chk("rst_addr",  bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_rdata", readdata_mem, 0);
    chk("rst_cnt",   cnt(), 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd,
            tbl[i].ack, tbl[i].brd);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_rdata", i), readdata_mem, tbl[i].e_rdata);
      chk($sformatf("v%0d_req", i), 32'(bus_req), 32'(tbl[i].e_req));
      chk($sformatf("v%0d_cnt", i), cnt(), 32'(tbl[i].e_cnt));
      if (tbl[i].e_req) begin
        chk($sformatf("v%0d_we", i), 32'(bus_we), 32'(tbl[i].e_we));
        chk($sformatf("v%0d_baddr", i), bus_addr, tbl[i].e_baddr);
        if (tbl[i].e_we)
          chk($sformatf("v%0d_bwd", i), bus_wdata, tbl[i].e_bwd);
      end
    end

    // S5: pending store drains before the load miss reaches the bus
    @(negedge clk);
    drive(0,1,32'h400,32'h44,0,0);
    #1;
    chk("s5_st_stall", 32'(stall), 0);
    ntx  = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      drive(1,0,32'h500,0,bus_req,32'h55AA0000);
      #1;
      if (bus_req && bus_ack && ntx < 4) begin
        tx_we[ntx]   = bus_we;
        tx_addr[ntx] = bus_addr;
        tx_wd[ntx]   = bus_wdata;
        ntx++;
      end
      if (!stall && ntx >= 2) begin
        done = 1'b1;
        chk("s5_rdata", readdata_mem, 32'h55AA0000);
      end
    end
    chk("s5_done", 32'(done), 1);
    chk("s5_ntx", 32'(ntx), 2);
    if (ntx >= 2) begin
      chk("s5_tx0_we", 32'(tx_we[0]), 1);
      chk("s5_tx0_addr", tx_addr[0], 32'h400);
      chk("s5_tx0_wd", tx_wd[0], 32'h44);
      chk("s5_tx1_we", 32'(tx_we[1]), 0);
      chk("s5_tx1_addr", tx_addr[1], 32'h500);
    end
    @(negedge clk);
    drive(0,0,0,0,0,0);

    // S6: reset in RD_BUSY with two buffered writes
    @(negedge clk);
    drive(1,0,32'h700,0,0,0);
    #1;
    chk("s6_miss_stall", 32'(stall), 1);
    @(negedge clk);
    drive(0,1,32'h800,32'h88,0,0);
    #1;
    chk("s6_rd_req", 32'(bus_req), 1);
    chk("s6_rd_we", 32'(bus_we), 0);
    chk("s6_rd_addr", bus_addr, 32'h700);
    chk("s6_st0_stall", 32'(stall), 0);
    @(negedge clk);
    drive(0,1,32'h804,32'h99,0,0);
    #1;
    chk("s6_cnt1", cnt(), 1);
    @(negedge clk);
    drive(0,0,0,0,0,0);
    reset = 1'b1;
    #1;
    chk("s6_cnt2", cnt(), 2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("s6_post_req", 32'(bus_req), 0);
    chk("s6_post_stall", 32'(stall), 0);
    chk("s6_post_cnt", cnt(), 0);
    chk("s6_post_rdata", readdata_mem, 0);
    @(negedge clk);
    drive(0,0,0,0,1,32'h12345678);
    #1;
    chk("s6_stray_req", 32'(bus_req), 0);
    @(negedge clk);
    drive(0,0,0,0,0,0);
    #1;
    chk("s6_after_req", 32'(bus_req), 0);
    chk("s6_after_stall", 32'(stall), 0);
    chk("s6_after_cnt", cnt(), 0);
    chk("s6_after_rdata", readdata_mem, 0);
    @(negedge clk);
    drive(1,0,32'h800,0,0,0);
    #1;
    chk("s6_discard_stall", 32'(stall), 1);
    chk("s6_discard_rdata", readdata_mem, 0);
    @(negedge clk);
    drive(0,0,0,0,0,0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_wbuf_ctrl.md
DMEM_WBUF_CTRL -- requirements
Module: dmem_wbuf_ctrl

Interface
REQ-001 Parameter WBUF_DEPTH, default 4, number of posted-write buffer entries (power of two, 2..16).
REQ-002 Parameter AW, default 32, byte-address width.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 memread_mem  in  1  MEM-stage load request.
REQ-006 memwrite_mem  in  1  MEM-stage store request.
REQ-007 aluout_mem  in  AW  byte address; bits [1:0] ignored (word access only).
REQ-008 writedata_mem  in  32  store data.
REQ-009 readdata_mem  out  32  load data to the MEM/WB register.
REQ-010 stall  out  1  freezes the pipeline while high.
REQ-011 bus_req  out  1  external memory request.
REQ-012 bus_we  out  1  1 = write, 0 = read.
REQ-013 bus_addr  out  AW  word-aligned address; bits [1:0] driven 0.
REQ-014 bus_wdata  out  32  write data.
REQ-015 bus_ack  in  1  one-cycle completion strobe.
REQ-016 bus_rdata  in  32  read data, valid only in the ack cycle.

Function
REQ-017 The store path SHALL post writes: if the buffer is not full, the write is enqueued at the clock edge, stall=0.
REQ-018 The store path SHALL hold stall=1 while the buffer is full. Enqueue occurs at the edge on which an entry drains; stall=0 in that same cycle.
REQ-019 Load hit: if any buffered entry matches aluout_mem[AW-1:2], readdata_mem SHALL combinationally return the youngest matching data, with stall=0 and no bus traffic.
REQ-020 Load miss: stall SHALL be 1 until the buffer is empty.
REQ-021 After the buffer empties, a load miss SHALL issue a bus read and then present the data as follows:
- stall stays 1 through the ack cycle;
- bus_rdata is registered;
- in the following cycle (state RD_DONE), readdata_mem shows the registered data with stall=0.
REQ-022 FSM states SHALL be:
- IDLE: no bus activity.
- WR_BUSY: head entry on the bus.
- RD_BUSY: load read on the bus.
- RD_DONE: one cycle, load data presented.
REQ-023 FSM transitions SHALL be:
- IDLE->WR_BUSY: buffer non-empty.
- IDLE->RD_BUSY: load miss and buffer empty.
- WR_BUSY->IDLE: on ack (head dequeued).
- RD_BUSY->RD_DONE: on ack.
- RD_DONE->IDLE: unconditional.
REQ-024 Drain priority: buffered writes SHALL always drain before a pending load miss issues (strict program order).
REQ-025 bus_req, bus_we, bus_addr and bus_wdata SHALL be registered and held stable from assertion until the ack cycle. bus_req SHALL be 0 in the cycle after ack.
REQ-026 bus_ack SHALL be ignored when bus_req=0. Bus latency is unbounded; no timeout.
REQ-027 If memread_mem and memwrite_mem are both 1, the write SHALL take precedence and the read is ignored.
REQ-028 Enqueue and dequeue in the same cycle SHALL leave the occupancy unchanged. Pointers SHALL wrap modulo WBUF_DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-029 readdata_mem SHALL be 0 when there is neither a hit nor RD_DONE.
REQ-030 A store to an address already buffered SHALL add a new entry (no merging). The youngest entry wins for forwarding.

Reset
REQ-031 On reset the module SHALL return to a defined idle state:
- state=IDLE;
- buffer empty;
- bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0;
- read data register=0;
- stall=0 when no request is present.
REQ-032 Reset mid-transaction SHALL abandon the transaction and discard all buffered writes. A later bus_ack SHALL be ignored.

Structure
REQ-033 WBUF_DEPTH default and the FSM state encoding SHALL live in the shared mips_mem_pkg package/header.
REQ-034 The buffer SHALL be a sub-module wbuf_fifo with:
- push/pop and full/empty flags;
- per-entry address/data outputs for the match logic.

Verification
REQ-035 The bench SHALL cover the following scenarios:
- Store 0x11111111 to 0x100 with bus_ack held off: stall=0 and entry count=1. Then bus_req=1, bus_we=1, bus_addr=0x100 until ack.
- Five back-to-back stores with bus_ack held off: the first four give stall=0; the fifth holds stall=1 until the first ack, then enqueues.
- Store 0xA to 0x200, then store 0xB to 0x200, then load 0x202 before any ack: readdata_mem=0xB with stall=0 in the same cycle.
- Load 0x300 with empty buffer and ack after 3 cycles carrying 0xDEADBEEF: stall=1 for 4 cycles, then readdata_mem=0xDEADBEEF with stall=0.
- Store to 0x400, then load 0x500: the bus write completes before bus_req shows we=0 for 0x500.
- Reset asserted in RD_BUSY with two buffered writes: next cycle bus_req=0 and stall=0; a subsequent stray ack causes no change.
